// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing one L2 request port among NUM_REQ clk_fast requesters; one outstanding transaction.
// Optional response timeout is compiled in with `define L2_ARB_TIMEOUT_EN (default build: no timer, error stays 0).
module l2_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk_fast,
  input  logic                      reset_n,
  input  logic                      l2_slot,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_we,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      l2_req_valid,
  output logic [ADDR_W-1:0]         l2_req_addr,
  output logic                      l2_req_we,
  input  logic                      l2_resp_valid,
  output logic [NUM_REQ-1:0]        done,
  output logic                      error,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = IDX_W + 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SLOT = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic               found_s;
  logic [IDX_W-1:0]   pick_s;
  logic [CW-1:0]      cand_s;
  logic [IDX_W-1:0]   rr_next_s;

  if (TIMEOUT_CYC < 2) begin : g_timeout_cfg_unused
  end

`ifdef L2_ARB_TIMEOUT_EN
  localparam int             TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] timer_q, timer_d;
`endif

  // Winner search: first set request at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IDX_W{1'b0}};
    cand_s  = {CW{1'b0}};
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = {1'b0, rr_ptr_q} + CW'(off);
      if (cand_s >= CW'(NUM_REQ)) begin
        cand_s = cand_s - CW'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IDX_W-1:0]]) begin
        found_s = 1'b1;
        pick_s  = cand_s[IDX_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign rr_next_s = (win_q == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : win_q + IDX_W'(1);

  // Transaction FSM next-state and output-register computation.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    we_d     = we_q;
    valid_d  = 1'b0;
    done_d   = {NUM_REQ{1'b0}};
    err_d    = 1'b0;
`ifdef L2_ARB_TIMEOUT_EN
    timer_d  = timer_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          win_d   = pick_s;
          addr_d  = req_addr[pick_s*ADDR_W +: ADDR_W];
          we_d    = req_we[pick_s];
          state_d = ST_WAIT_SLOT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_SLOT: begin
        if (l2_slot) begin
          valid_d = 1'b1;
          state_d = ST_WAIT_RESP;
`ifdef L2_ARB_TIMEOUT_EN
          timer_d = {TO_W{1'b0}};
`endif
        end else begin
          state_d = ST_WAIT_SLOT;
        end
      end
      ST_WAIT_RESP: begin
        // A response arriving together with expiry takes priority, so error stays low.
        if (l2_resp_valid) begin
          done_d   = grant_q;
          grant_d  = {NUM_REQ{1'b0}};
          rr_ptr_d = rr_next_s;
          state_d  = ST_IDLE;
`ifdef L2_ARB_TIMEOUT_EN
        end else if (timer_q == TO_LAST) begin
          done_d   = grant_q;
          err_d    = 1'b1;
          grant_d  = {NUM_REQ{1'b0}};
          rr_ptr_d = rr_next_s;
          state_d  = ST_IDLE;
        end else begin
          timer_d  = timer_q + TO_W'(1);
          state_d  = ST_WAIT_RESP;
        end
`else
        end else begin
          state_d  = ST_WAIT_RESP;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_REQ{1'b0}};
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction without a completion pulse.
  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= {NUM_REQ{1'b0}};
      win_q    <= {IDX_W{1'b0}};
      rr_ptr_q <= {IDX_W{1'b0}};
      addr_q   <= {ADDR_W{1'b0}};
      we_q     <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= {NUM_REQ{1'b0}};
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef L2_ARB_TIMEOUT_EN
      timer_q  <= {TO_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
`ifdef L2_ARB_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign l2_req_valid = valid_q;
  assign l2_req_addr  = addr_q;
  assign l2_req_we    = we_q;
  assign done         = done_q;
  assign error        = err_q;
  assign busy         = busy_q;

endmodule
